// File: rtl/acc_pkg.sv
// acc_pkg: shared width default and saturation mode constants for the accumulator
package acc_pkg;
   localparam int ACC_WIDTH_DEFAULT = 16;
   localparam bit ACC_WRAP = 1'b0;
   localparam bit ACC_SAT = 1'b1;
endpackage

// File: rtl/acc_adder.sv
// acc_adder: combinational WIDTH-bit adder producing sum and carry-out
module acc_adder #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum,
   output logic             carry
);
   assign {carry, sum} = {1'b0, a} + {1'b0, b};
endmodule

// File: rtl/acc.sv
// acc: registered unsigned accumulator with optional saturation, carry flag and zero detect
module acc
   import acc_pkg::*;
#(
   parameter int WIDTH = ACC_WIDTH_DEFAULT,
   parameter bit SATURATE = ACC_WRAP
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic [WIDTH-1:0] in_data,
   output logic [WIDTH-1:0] out_data,
   output logic             carry,
   output logic             zero
);
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] next;
   logic             co;
   acc_adder #(.WIDTH(WIDTH)) adder (
      .a(out_data),
      .b(in_data),
      .sum(sum),
      .carry(co)
   );
   // carry reports the adder overflow in both modes; only the data clamps
   assign next = (SATURATE == ACC_SAT && co) ? '1 : sum;
   assign zero = out_data == '0;
   always_ff @(posedge clk) begin
      if (rst) begin
         out_data <= '0;
         carry <= 1'b0;
      end else if (enable) begin
         out_data <= next;
         carry <= co;
      end
   end
endmodule

// File: tb/tb_acc.sv
// tb_acc: randomized scoreboard bench running wrap and saturating accumulators side by side
module tb_acc;
   typedef struct {
      int w_out;
      int w_carry;
      int s_out;
      int s_carry;
   } exp_t;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic [15:0] in_data = '0;
   logic [15:0] w_data, s_data;
   logic        w_carry, s_carry, w_zero, s_zero;
   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   int          w_acc = 0, s_acc = 0, w_c = 0, s_c = 0;
   always #5 clk = ~clk;
   acc #(.WIDTH(16), .SATURATE(1'b0)) dut_wrap (
      .clk(clk), .rst(rst), .enable(enable), .in_data(in_data),
      .out_data(w_data), .carry(w_carry), .zero(w_zero)
   );
   acc #(.WIDTH(16), .SATURATE(1'b1)) dut_sat (
      .clk(clk), .rst(rst), .enable(enable), .in_data(in_data),
      .out_data(s_data), .carry(s_carry), .zero(s_zero)
   );
   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask
   // Reference: plain integer arithmetic against 2^16, pushed when the edge happens
   task automatic step(input bit r, input bit e, input int d);
      int s;
      @(negedge clk);
      rst = r;
      enable = e;
      in_data = d[15:0];
      @(posedge clk);
      if (r) begin
         w_acc = 0; s_acc = 0; w_c = 0; s_c = 0;
      end else if (e) begin
         s = w_acc + d;
         w_c = (s > 65535) ? 1 : 0;
         w_acc = s % 65536;
         s = s_acc + d;
         s_c = (s > 65535) ? 1 : 0;
         s_acc = s_c ? 65535 : s;
      end
      sb.push_back('{w_acc, w_c, s_acc, s_c});
      #1 in_data = 16'($urandom);
   endtask
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t x;
         x = sb.pop_front();
         chk("wrap_out", int'(w_data), x.w_out);
         chk("wrap_carry", int'(w_carry), x.w_carry);
         chk("wrap_zero", int'(w_zero), (x.w_out == 0) ? 1 : 0);
         chk("sat_out", int'(s_data), x.s_out);
         chk("sat_carry", int'(s_carry), x.s_carry);
         chk("sat_zero", int'(s_zero), (x.s_out == 0) ? 1 : 0);
      end
   end
   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end
   initial begin
      int d;
      step(1, 0, 0);
      step(1, 0, 0);
      chk("reset_zero", int'(w_zero & s_zero), 1);
      step(0, 1, 3);
      step(0, 1, 7);
      step(0, 0, 1234);
      step(0, 0, 99);
      chk("hold_10", int'(w_data), 10);
      step(1, 0, 0);
      repeat (4) step(0, 1, 5);
      chk("multi_20", int'(s_data), 20);
      step(1, 0, 0);
      step(0, 1, 16'hFFFE);
      step(0, 1, 3);
      chk("wrap_1", int'({w_carry, w_data}), 17'h10001);
      step(0, 1, 1);
      chk("wrap_2", int'({w_carry, w_data}), 17'h00002);
      step(1, 0, 0);
      step(0, 1, 16'hFFF0);
      step(0, 1, 16'h0020);
      chk("sat_ffff", int'({s_carry, s_data}), 17'h1FFFF);
      step(0, 1, 0);
      chk("add_zero", int'({s_carry, s_data}), 17'h0FFFF);
      step(1, 1, 9);
      chk("rst_prio", int'(w_data), 0);
      step(0, 1, 9);
      chk("after_rst", int'(w_data), 9);
      repeat (400) begin
         case ($urandom_range(0, 2))
            0: d = int'($urandom_range(0, 15));
            1: d = int'($urandom_range(16'hF000, 16'hFFFF));
            default: d = int'($urandom_range(0, 16'hFFFF));
         endcase
         step($urandom_range(0, 49) == 0, $urandom_range(0, 2) != 0, d);
      end
      @(negedge clk);
      #1;
      chk("drain", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/acc.md
ACC -- requirements
Module: acc

Interface
REQ-001 Parameter WIDTH, default 16: data width of in_data, out_data and the internal register.
REQ-002 Parameter SATURATE, default 0: 0 = modulo-2^WIDTH wrap-around; 1 = unsigned saturation at 2^WIDTH-1.
REQ-003 There SHALL be one clock, and reset SHALL be synchronous and active-high.
REQ-004 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 Port enable, input, 1 bit: accumulate strobe, sampled on the rising clk edge.
REQ-007 Port in_data, input, WIDTH bits: unsigned addend.
REQ-008 Port out_data, output, WIDTH bits: registered accumulator value.
REQ-009 Port carry, output, 1 bit: registered carry-out of the most recent accumulate.
REQ-010 Port zero, output, 1 bit: combinational, 1 when out_data == 0.
REQ-011 carry and zero MAY be left unconnected by instantiating blocks; the block SHALL function identically when they are.

Function
REQ-012 Each rising clk edge with rst=0 and enable=1 SHALL set out_data <= out_data + in_data; the result is visible one cycle after the sampling edge (latency 1).
REQ-013 A rising edge with enable=0 SHALL hold out_data and carry unchanged, whatever the value of in_data.
REQ-014 Each enable pulse SHALL accumulate exactly once per rising edge it spans; an enable held for N edges SHALL accumulate N times.
REQ-015 in_data SHALL be sampled only at the rising edge; changes between edges SHALL have no effect.
REQ-016 Width rule: the sum is computed WIDTH+1 bits wide; bit WIDTH is the carry.
REQ-017 With SATURATE=0, out_data SHALL take the sum's low WIDTH bits (wrap) and carry SHALL take bit WIDTH.
REQ-018 With SATURATE=1, when bit WIDTH=1: out_data SHALL become all-ones and carry SHALL be set to 1.
REQ-019 With SATURATE=1, when bit WIDTH=0: out_data SHALL take the sum and carry SHALL be set to 0.
REQ-020 in_data=0 with enable=1 SHALL leave out_data unchanged and set carry=0.
REQ-021 No internal state machine; the accumulator register and the carry flop are the only state.

Reset
REQ-022 rst=1 at a rising edge SHALL set out_data=0 and carry=0; consequently zero SHALL read 1.
REQ-023 rst SHALL take priority over a simultaneous enable=1; that edge performs no accumulation.
REQ-024 Reset asserted mid-sequence SHALL discard all accumulated value; accumulation restarts from 0 on the first enabled edge with rst=0.
REQ-025 Before the first reset, outputs are undefined; the bench SHALL apply rst before checking.

Structure
REQ-026 A shared package acc_pkg SHALL hold ACC_WIDTH_DEFAULT=16 and the saturation mode constants (ACC_WRAP=0, ACC_SAT=1).
REQ-027 The block SHALL contain one sub-module, acc_adder: combinational, WIDTH-bit, producing sum and carry-out, with the saturation mux in acc.
REQ-028 The block SHALL contain no latches and no asynchronous logic other than the zero compare.

Verification
REQ-029 Directed scenario, reset: rst=1 for 2 edges -> out_data=0, carry=0, zero=1.
REQ-030 Directed scenario, basic accumulate: in_data=3, enable for 1 edge -> out_data=3; then in_data=7, enable for 1 edge -> out_data=10; in_data changes while enable=0 -> out_data holds 10.
REQ-031 Directed scenario, multi-edge enable: enable held 4 edges with in_data=5 from 0 -> out_data=20.
REQ-032 Directed scenario, wrap (SATURATE=0): out_data=0xFFFE plus in_data=0x0003 -> out_data=0x0001, carry=1; a next enable with in_data=1 -> out_data=0x0002, carry=0.
REQ-033 Directed scenario, saturate (SATURATE=1): out_data=0xFFF0 plus in_data=0x0020 -> out_data=0xFFFF, carry=1.
REQ-034 Directed scenario, reset priority: rst=1 with enable=1 and in_data=9 on the same edge -> out_data=0; the next edge with enable=1 -> out_data=9.
